// File: rtl/fir_pkg.sv
// Shared helpers for the 2-parallel fast FIR: accumulator sizing, address width,
// and the round/saturate output scaler used by the top level.
package fir_pkg;

  localparam int WIDE_W = 128;
  typedef logic signed [WIDE_W-1:0] wide_t;

  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + 2 + $clog2(taps / 2);
  endfunction

  function automatic int addr_width(input int taps);
    return (taps > 2) ? $clog2(taps) : 1;
  endfunction

  // Round half toward +inf, then clamp or wrap; callers keep the low out_w bits.
  function automatic wide_t round_sat(input wide_t v, input int shift, input int out_w,
                                      input logic sat_en);
    wide_t r;
    wide_t hi;
    wide_t lo;
    r = v;
    if (shift > 0) r = (v + (wide_t'(1) <<< (shift - 1))) >>> shift;
    hi = (wide_t'(1) <<< (out_w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (out_w - 1));
    if (sat_en) begin
      if (r > hi) r = hi;
      else if (r < lo) r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_subfilter.sv
// Combinational signed dot product of N packed samples with N packed coefficients,
// accumulated at ACC_W bits.
module fir_subfilter #(
  parameter int N     = 4,
  parameter int A_W   = 16,
  parameter int C_W   = 32,
  parameter int ACC_W = 52
) (
  input  logic [N*A_W-1:0] samp_i,
  input  logic [N*C_W-1:0] coef_i,
  output logic [ACC_W-1:0] sum_o
);

  logic signed [ACC_W-1:0] prod [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_tap
      logic signed [ACC_W-1:0] s_ext;
      logic signed [ACC_W-1:0] c_ext;
      assign s_ext    = ACC_W'($signed(samp_i[gi*A_W +: A_W]));
      assign c_ext    = ACC_W'($signed(coef_i[gi*C_W +: C_W]));
      assign prod[gi] = s_ext * c_ext;
    end
  endgenerate

  always_comb begin
    sum_o = '0;
    for (int i = 0; i < N; i++) sum_o = sum_o + prod[i];
  end

endmodule

// File: rtl/fir_fast_parallel2.sv
// 2-parallel fast FIR (H0, H1, H0+H1 subfilters) with loadable coefficients,
// valid-qualified sample history and a two-stage registered output path.
module fir_fast_parallel2
  import fir_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int COEF_W     = 32,
  parameter int TAPS       = 102,
  parameter int OUT_W      = 32,
  parameter int FRAC_SHIFT = 31,
  parameter int SAT_EN     = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clear,
  input  logic                                in_valid,
  input  logic signed [DATA_W-1:0]            din0,
  input  logic signed [DATA_W-1:0]            din1,
  input  logic                                coef_we,
  input  logic [fir_pkg::addr_width(TAPS)-1:0] coef_addr,
  input  logic signed [COEF_W-1:0]            coef_data,
  output logic                                out_valid,
  output logic [OUT_W-1:0]                    dout0,
  output logic [OUT_W-1:0]                    dout1
);

  localparam int HALF  = TAPS / 2;
  localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
  localparam int AW    = addr_width(TAPS);

  logic signed [DATA_W-1:0] buf0_q [HALF];
  logic signed [DATA_W-1:0] buf1_q [HALF];
  logic signed [COEF_W-1:0] h0_q   [HALF];
  logic signed [COEF_W-1:0] h1_q   [HALF];
  logic signed [COEF_W:0]   h01_q  [HALF];

  logic [HALF*DATA_W-1:0]     buf0_flat;
  logic [HALF*DATA_W-1:0]     buf1_flat;
  logic [HALF*(DATA_W+1)-1:0] bsum_flat;
  logic [HALF*COEF_W-1:0]     h0_flat;
  logic [HALF*COEF_W-1:0]     h1_flat;
  logic [HALF*(COEF_W+1)-1:0] h01_flat;

  logic [ACC_W-1:0] s_h0_c, s_h1_c, s_h01_c;
  logic signed [ACC_W-1:0] s_h0_q, s_h1_q, s_h01_q, h1_prev_q;
  logic signed [ACC_W-1:0] y0_full, y1_full;
  logic fresh_q, v1_q, out_valid_q;
  logic [OUT_W-1:0] dout0_q, dout1_q, dout0_d, dout1_d;

  genvar gi;
  generate
    for (gi = 0; gi < HALF; gi++) begin : g_flat
      assign buf0_flat[gi*DATA_W +: DATA_W] = buf0_q[gi];
      assign buf1_flat[gi*DATA_W +: DATA_W] = buf1_q[gi];
      assign bsum_flat[gi*(DATA_W+1) +: DATA_W+1] =
        {buf0_q[gi][DATA_W-1], buf0_q[gi]} + {buf1_q[gi][DATA_W-1], buf1_q[gi]};
      assign h0_flat[gi*COEF_W +: COEF_W]          = h0_q[gi];
      assign h1_flat[gi*COEF_W +: COEF_W]          = h1_q[gi];
      assign h01_flat[gi*(COEF_W+1) +: COEF_W+1]   = h01_q[gi];
    end
  endgenerate

  fir_subfilter #(.N(HALF), .A_W(DATA_W), .C_W(COEF_W), .ACC_W(ACC_W)) u_h0 (
    .samp_i(buf0_flat), .coef_i(h0_flat), .sum_o(s_h0_c)
  );
  fir_subfilter #(.N(HALF), .A_W(DATA_W), .C_W(COEF_W), .ACC_W(ACC_W)) u_h1 (
    .samp_i(buf1_flat), .coef_i(h1_flat), .sum_o(s_h1_c)
  );
  fir_subfilter #(.N(HALF), .A_W(DATA_W+1), .C_W(COEF_W+1), .ACC_W(ACC_W)) u_h01 (
    .samp_i(bsum_flat), .coef_i(h01_flat), .sum_o(s_h01_c)
  );

  // Even taps land in H0, odd taps in H1; the H0+H1 slot follows whichever half changed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HALF; i++) begin
        h0_q[i]  <= '0;
        h1_q[i]  <= '0;
        h01_q[i] <= '0;
      end
    end else if (coef_we) begin
      for (int i = 0; i < HALF; i++) begin
        if (coef_addr == AW'(2*i)) begin
          h0_q[i]  <= coef_data;
          h01_q[i] <= {coef_data[COEF_W-1], coef_data} + {h1_q[i][COEF_W-1], h1_q[i]};
        end
        if (coef_addr == AW'(2*i+1)) begin
          h1_q[i]  <= coef_data;
          h01_q[i] <= {h0_q[i][COEF_W-1], h0_q[i]} + {coef_data[COEF_W-1], coef_data};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HALF; i++) begin
        buf0_q[i] <= '0;
        buf1_q[i] <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < HALF; i++) begin
        buf0_q[i] <= '0;
        buf1_q[i] <= '0;
      end
    end else if (in_valid) begin
      buf0_q[0] <= din0;
      buf1_q[0] <= din1;
      for (int i = 1; i < HALF; i++) begin
        buf0_q[i] <= buf0_q[i-1];
        buf1_q[i] <= buf1_q[i-1];
      end
    end
  end

  always_comb begin
    y0_full = s_h0_q + h1_prev_q;
    y1_full = s_h01_q - s_h0_q - s_h1_q;
    dout0_d = OUT_W'(round_sat(wide_t'(y0_full), FRAC_SHIFT, OUT_W, SAT_EN != 0));
    dout1_d = OUT_W'(round_sat(wide_t'(y1_full), FRAC_SHIFT, OUT_W, SAT_EN != 0));
  end

  // fresh_q flags that the buffers just took a block; v1_q lines up with the sums of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_h0_q      <= '0;
      s_h1_q      <= '0;
      s_h01_q     <= '0;
      h1_prev_q   <= '0;
      fresh_q     <= 1'b0;
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      dout0_q     <= '0;
      dout1_q     <= '0;
    end else begin
      s_h0_q  <= s_h0_c;
      s_h1_q  <= s_h1_c;
      s_h01_q <= s_h01_c;
      if (clear) begin
        fresh_q     <= 1'b0;
        v1_q        <= 1'b0;
        h1_prev_q   <= '0;
        out_valid_q <= 1'b0;
      end else begin
        fresh_q     <= in_valid;
        v1_q        <= fresh_q;
        out_valid_q <= v1_q;
        if (v1_q) begin
          h1_prev_q <= s_h1_q;
          dout0_q   <= dout0_d;
          dout1_q   <= dout1_d;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign dout0     = dout0_q;
  assign dout1     = dout1_q;

endmodule

// File: tb/tb_fir_fast_parallel2.sv
// Bench for fir_fast_parallel2: four parameterisations checked against a serial
// convolution model y(n) = sum h(m) x(n-m) followed by round/saturate/wrap.
module tb_fir_fast_parallel2;

  logic clk;
  logic rst_n;

  logic              iv    [4];
  logic              clr   [4];
  logic              cwe   [4];
  logic signed [15:0] d0   [4];
  logic signed [15:0] d1   [4];
  logic [7:0]        caddr [4];
  logic [31:0]       cdata [4];
  logic              ov    [4];
  logic [31:0]       o0    [4];
  logic [31:0]       o1    [4];

  logic ov_a, ov_b, ov_c, ov_d;
  logic [23:0] a_o0, a_o1;
  logic [15:0] b_o0, b_o1, c_o0, c_o1;
  logic [19:0] d_o0, d_o1;

  int taps_p [4] = '{4, 2, 2, 6};
  int fs_p   [4] = '{0, 1, 0, 8};
  int ow_p   [4] = '{24, 16, 16, 20};
  int sat_p  [4] = '{1, 1, 1, 0};

  int n_vec;
  int n_err;

  // reference model state
  longint      xs   [4][0:2047];
  int          xn   [4];
  longint      hc   [4][8];
  bit          pv   [4][3];
  logic [31:0] pe0  [4][3];
  logic [31:0] pe1  [4][3];
  logic [31:0] last0 [4];
  logic [31:0] last1 [4];
  bit          ev;
  logic [31:0] e0, e1;

  fir_fast_parallel2 #(.DATA_W(16), .COEF_W(32), .TAPS(4), .OUT_W(24), .FRAC_SHIFT(0), .SAT_EN(1)) u_a (
    .clk(clk), .rst_n(rst_n), .clear(clr[0]), .in_valid(iv[0]), .din0(d0[0]), .din1(d1[0]),
    .coef_we(cwe[0]), .coef_addr(caddr[0][1:0]), .coef_data(cdata[0]),
    .out_valid(ov_a), .dout0(a_o0), .dout1(a_o1));
  fir_fast_parallel2 #(.DATA_W(16), .COEF_W(32), .TAPS(2), .OUT_W(16), .FRAC_SHIFT(1), .SAT_EN(1)) u_b (
    .clk(clk), .rst_n(rst_n), .clear(clr[1]), .in_valid(iv[1]), .din0(d0[1]), .din1(d1[1]),
    .coef_we(cwe[1]), .coef_addr(caddr[1][0:0]), .coef_data(cdata[1]),
    .out_valid(ov_b), .dout0(b_o0), .dout1(b_o1));
  fir_fast_parallel2 #(.DATA_W(16), .COEF_W(32), .TAPS(2), .OUT_W(16), .FRAC_SHIFT(0), .SAT_EN(1)) u_c (
    .clk(clk), .rst_n(rst_n), .clear(clr[2]), .in_valid(iv[2]), .din0(d0[2]), .din1(d1[2]),
    .coef_we(cwe[2]), .coef_addr(caddr[2][0:0]), .coef_data(cdata[2]),
    .out_valid(ov_c), .dout0(c_o0), .dout1(c_o1));
  fir_fast_parallel2 #(.DATA_W(16), .COEF_W(20), .TAPS(6), .OUT_W(20), .FRAC_SHIFT(8), .SAT_EN(0)) u_d (
    .clk(clk), .rst_n(rst_n), .clear(clr[3]), .in_valid(iv[3]), .din0(d0[3]), .din1(d1[3]),
    .coef_we(cwe[3]), .coef_addr(caddr[3][2:0]), .coef_data(cdata[3][19:0]),
    .out_valid(ov_d), .dout0(d_o0), .dout1(d_o1));

  assign ov[0] = ov_a;  assign o0[0] = {8'b0, a_o0};  assign o1[0] = {8'b0, a_o1};
  assign ov[1] = ov_b;  assign o0[1] = {16'b0, b_o0}; assign o1[1] = {16'b0, b_o1};
  assign ov[2] = ov_c;  assign o0[2] = {16'b0, c_o0}; assign o1[2] = {16'b0, c_o1};
  assign ov[3] = ov_d;  assign o0[3] = {12'b0, d_o0}; assign o1[3] = {12'b0, d_o1};

  always #5 clk = ~clk;

  function automatic logic [31:0] fmt(input longint y, input int u);
    longint r, hi, lo;
    logic [63:0] t;
    r = y;
    if (fs_p[u] > 0) r = (y + (longint'(1) <<< (fs_p[u] - 1))) >>> fs_p[u];
    if (sat_p[u] != 0) begin
      hi = (longint'(1) <<< (ow_p[u] - 1)) - 1;
      lo = -hi - 1;
      if (r > hi) r = hi;
      if (r < lo) r = lo;
    end
    t = r;
    t = t & ((64'd1 << ow_p[u]) - 64'd1);
    return t[31:0];
  endfunction

  function automatic longint yref(input int u, input int n);
    longint s;
    s = 0;
    for (int m = 0; m < taps_p[u]; m++)
      if (n - m >= 0) s += hc[u][m] * xs[u][n-m];
    return s;
  endfunction

  task automatic reset_models();
    for (int u = 0; u < 4; u++) begin
      xn[u] = 0;
      for (int m = 0; m < 8; m++) hc[u][m] = 0;
      for (int p = 0; p < 3; p++) pv[u][p] = 0;
      last0[u] = 0;
      last1[u] = 0;
    end
  endtask

  // One clock for instance u; leaves ev/e0/e1 as the outputs expected after that edge.
  task automatic step(input int u, input bit v, input longint a, input longint b,
                      input bit c, input bit we, input int addr, input longint cd);
    iv[u] = v; d0[u] = 16'(a); d1[u] = 16'(b); clr[u] = c;
    cwe[u] = we; caddr[u] = 8'(addr); cdata[u] = 32'(cd);
    @(posedge clk);
    pv[u][2] = pv[u][1];  pe0[u][2] = pe0[u][1];  pe1[u][2] = pe1[u][1];
    pv[u][1] = pv[u][0];  pe0[u][1] = pe0[u][0];  pe1[u][1] = pe1[u][0];
    pv[u][0] = 0;
    if (c) begin
      xn[u] = 0;
      for (int p = 0; p < 3; p++) pv[u][p] = 0;
    end else if (v) begin
      xs[u][xn[u]] = a;
      xs[u][xn[u]+1] = b;
      xn[u] += 2;
      pv[u][0] = 1;
      pe0[u][0] = fmt(yref(u, xn[u] - 2), u);
      pe1[u][0] = fmt(yref(u, xn[u] - 1), u);
    end
    if (we && addr < taps_p[u]) hc[u][addr] = cd;
    ev = pv[u][2];
    if (ev) begin
      last0[u] = pe0[u][2];
      last1[u] = pe1[u][2];
    end
    e0 = last0[u];
    e1 = last1[u];
    @(negedge clk);
    iv[u] = 0; clr[u] = 0; cwe[u] = 0;
  endtask

  task automatic load_coefs(input int u, input longint h [8]);
    for (int m = 0; m < taps_p[u]; m++) step(u, 0, 0, 0, 0, 1, m, h[m]);
    step(u, 0, 0, 0, 1, 0, 0, 0);
    step(u, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int u = 0; u < 4; u++) begin
      n_vec += 3;
      if (ov[u] !== 1'b0) begin n_err++; $display("FAIL reset_valid u%0d: got %0b want 0", u, ov[u]); end
      if (o0[u] !== 32'h0) begin n_err++; $display("FAIL reset_dout0 u%0d: got %0h want 0", u, o0[u]); end
      if (o1[u] !== 32'h0) begin n_err++; $display("FAIL reset_dout1 u%0d: got %0h want 0", u, o1[u]); end
    end
    $display("reset: outputs idle on all instances");
    rst_n = 1;
  endtask

  task automatic test_impulse_even();
    longint h [8];
    int tbl [8];
    int idx;
    h = '{1, 2, 3, 4, 0, 0, 0, 0};
    tbl = '{1, 2, 3, 4, 0, 0, 0, 0};
    idx = 0;
    load_coefs(0, h);
    for (int k = 0; k < 7; k++) begin
      step(0, k < 4, (k == 0) ? 1 : 0, 0, 0, 0, 0, 0);
      n_vec++;
      if (ov[0] !== ev || o0[0] !== e0 || o1[0] !== e1) begin
        n_err++;
        $display("FAIL impulse_even k=%0d: got v=%0b %0h %0h want v=%0b %0h %0h", k, ov[0], o0[0], o1[0], ev, e0, e1);
      end else if (ev) $display("impulse_even k=%0d y0=%0h y1=%0h", k, e0, e1);
      if (ov[0] === 1'b1 && idx < 4) begin
        n_vec++;
        if (o0[0] !== 32'(tbl[2*idx]) || o1[0] !== 32'(tbl[2*idx+1])) begin
          n_err++;
          $display("FAIL impulse_even_tbl blk=%0d: got %0h %0h want %0h %0h", idx, o0[0], o1[0], tbl[2*idx], tbl[2*idx+1]);
        end
        idx++;
      end
    end
    n_vec++;
    if (idx != 4) begin n_err++; $display("FAIL impulse_even_count: got %0d want 4", idx); end
  endtask

  task automatic test_impulse_odd();
    step(0, 0, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      step(0, k < 3, 0, (k == 0) ? 1 : 0, 0, 0, 0, 0);
      n_vec++;
      if (ov[0] !== ev || o0[0] !== e0 || o1[0] !== e1) begin
        n_err++;
        $display("FAIL impulse_odd k=%0d: got v=%0b %0h %0h want v=%0b %0h %0h", k, ov[0], o0[0], o1[0], ev, e0, e1);
      end else if (ev) $display("impulse_odd k=%0d y0=%0h y1=%0h", k, e0, e1);
    end
  endtask

  task automatic test_valid_gaps();
    int pulses;
    pulses = 0;
    step(0, 0, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 14; k++) begin
      step(0, (k % 4 == 0) && k < 12, 0, (k == 0) ? 1 : 0, 0, 0, 0, 0);
      if (ov[0] === 1'b1) pulses++;
      n_vec++;
      if (ov[0] !== ev || o0[0] !== e0 || o1[0] !== e1) begin
        n_err++;
        $display("FAIL valid_gaps k=%0d: got v=%0b %0h %0h want v=%0b %0h %0h", k, ov[0], o0[0], o1[0], ev, e0, e1);
      end else if (ev) $display("valid_gaps k=%0d y0=%0h y1=%0h", k, e0, e1);
    end
    n_vec++;
    if (pulses != 3) begin n_err++; $display("FAIL valid_gaps_pulses: got %0d want 3", pulses); end
  endtask

  task automatic test_clear_mid_stream();
    for (int k = 0; k < 12; k++) begin
      if (k < 3)
        step(0, 1, int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 2000)) - 1000, 0, 0, 0, 0);
      else if (k == 3)
        step(0, 1, 77, -55, 1, 0, 0, 0);
      else
        step(0, k < 7, (k == 4) ? 1 : 0, 0, 0, 0, 0, 0);
      n_vec++;
      if (ov[0] !== ev || o0[0] !== e0 || o1[0] !== e1) begin
        n_err++;
        $display("FAIL clear_mid k=%0d: got v=%0b %0h %0h want v=%0b %0h %0h", k, ov[0], o0[0], o1[0], ev, e0, e1);
      end else if (ev) $display("clear_mid k=%0d y0=%0h y1=%0h", k, e0, e1);
    end
  endtask

  task automatic test_back_to_back_random();
    longint h [8];
    for (int m = 0; m < 8; m++) h[m] = int'($urandom_range(0, 400)) - 200;
    load_coefs(0, h);
    for (int k = 0; k < 120; k++) begin
      step(0, $urandom_range(0, 9) < 7, int'($urandom_range(0, 2000)) - 1000,
           int'($urandom_range(0, 2000)) - 1000, $urandom_range(0, 32) == 0, 0, 0, 0);
      n_vec++;
      if (ov[0] !== ev || o0[0] !== e0 || o1[0] !== e1) begin
        n_err++;
        $display("FAIL random_a k=%0d: got v=%0b %0h %0h want v=%0b %0h %0h", k, ov[0], o0[0], o1[0], ev, e0, e1);
      end else if (ev) $display("random_a k=%0d y0=%0h y1=%0h", k, e0, e1);
    end
  endtask

  task automatic test_rounding();
    longint h [8];
    logic [31:0] want [2];
    int idx;
    h = '{1, 0, 0, 0, 0, 0, 0, 0};
    want = '{32'h0002, 32'hFFFF};
    idx = 0;
    load_coefs(1, h);
    for (int k = 0; k < 4; k++) begin
      step(1, k < 2, (k == 0) ? 3 : -3, 0, 0, 0, 0, 0);
      n_vec++;
      if (ov[1] !== ev || o0[1] !== e0 || o1[1] !== e1) begin
        n_err++;
        $display("FAIL rounding k=%0d: got v=%0b %0h %0h want v=%0b %0h %0h", k, ov[1], o0[1], o1[1], ev, e0, e1);
      end else if (ev) $display("rounding k=%0d y0=%0h y1=%0h", k, e0, e1);
      if (ov[1] === 1'b1 && idx < 2) begin
        n_vec++;
        if (o0[1] !== want[idx]) begin
          n_err++;
          $display("FAIL rounding_lit blk=%0d: got %0h want %0h", idx, o0[1], want[idx]);
        end
        idx++;
      end
    end
  endtask

  task automatic test_saturation();
    longint h [8];
    logic [31:0] want [2];
    int idx;
    h = '{32767, 32767, 0, 0, 0, 0, 0, 0};
    want = '{32'h7FFF, 32'h8000};
    idx = 0;
    load_coefs(2, h);
    for (int k = 0; k < 8; k++) begin
      if (k == 0)      step(2, 1, 32767, 32767, 0, 0, 0, 0);
      else if (k == 3) step(2, 0, 0, 0, 1, 0, 0, 0);
      else if (k == 4) step(2, 1, -32768, -32768, 0, 0, 0, 0);
      else             step(2, 0, 0, 0, 0, 0, 0, 0);
      n_vec++;
      if (ov[2] !== ev || o0[2] !== e0 || o1[2] !== e1) begin
        n_err++;
        $display("FAIL saturation k=%0d: got v=%0b %0h %0h want v=%0b %0h %0h", k, ov[2], o0[2], o1[2], ev, e0, e1);
      end else if (ev) $display("saturation k=%0d y0=%0h y1=%0h", k, e0, e1);
      if (ov[2] === 1'b1 && idx < 2) begin
        n_vec++;
        if (o0[2] !== want[idx] || o1[2] !== want[idx]) begin
          n_err++;
          $display("FAIL saturation_lit blk=%0d: got %0h %0h want %0h", idx, o0[2], o1[2], want[idx]);
        end
        idx++;
      end
    end
  endtask

  task automatic test_wrap_random();
    longint h [8];
    for (int m = 0; m < 8; m++) h[m] = int'($urandom_range(0, 1048575)) - 524288;
    for (int m = 0; m < 6; m++) step(3, 0, 0, 0, 0, 1, m, h[m]);
    // out-of-range addresses must not disturb the taps
    step(3, 0, 0, 0, 0, 1, 6, 12345);
    step(3, 0, 0, 0, 0, 1, 7, -4321);
    step(3, 0, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 150; k++) begin
      step(3, $urandom_range(0, 9) < 6, int'($urandom_range(0, 65535)) - 32768,
           int'($urandom_range(0, 65535)) - 32768, $urandom_range(0, 49) == 0, 0, 0, 0);
      n_vec++;
      if (ov[3] !== ev || o0[3] !== e0 || o1[3] !== e1) begin
        n_err++;
        $display("FAIL wrap_random k=%0d: got v=%0b %0h %0h want v=%0b %0h %0h", k, ov[3], o0[3], o1[3], ev, e0, e1);
      end else if (ev) $display("wrap_random k=%0d y0=%0h y1=%0h", k, e0, e1);
    end
  endtask

  task automatic test_async_reset();
    int pulses;
    pulses = 0;
    for (int k = 0; k < 3; k++)
      step(0, 1, int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 2000)) - 1000, 0, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    n_vec += 3;
    if (ov[0] !== 1'b0) begin n_err++; $display("FAIL async_reset_valid: got %0b want 0", ov[0]); end
    if (o0[0] !== 32'h0) begin n_err++; $display("FAIL async_reset_dout0: got %0h want 0", o0[0]); end
    if (o1[0] !== 32'h0) begin n_err++; $display("FAIL async_reset_dout1: got %0h want 0", o1[0]); end
    $display("async_reset: outputs dropped mid-cycle");
    reset_models();
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 6; k++) begin
      step(0, k < 3, (k == 0) ? 1 : 0, 0, 0, 0, 0, 0);
      if (ov[0] === 1'b1) pulses++;
      n_vec++;
      if (ov[0] !== ev || o0[0] !== e0 || o1[0] !== e1) begin
        n_err++;
        $display("FAIL post_reset k=%0d: got v=%0b %0h %0h want v=%0b %0h %0h", k, ov[0], o0[0], o1[0], ev, e0, e1);
      end else if (ev) $display("post_reset k=%0d y0=%0h y1=%0h", k, e0, e1);
    end
    n_vec++;
    if (pulses != 3) begin n_err++; $display("FAIL post_reset_pulses: got %0d want 3", pulses); end
  endtask

  initial begin
    clk = 0;
    rst_n = 0;
    n_vec = 0;
    n_err = 0;
    for (int u = 0; u < 4; u++) begin
      iv[u] = 0; clr[u] = 0; cwe[u] = 0;
      d0[u] = 0; d1[u] = 0; caddr[u] = 0; cdata[u] = 0;
    end
    reset_models();
    test_reset();
    test_impulse_even();
    test_impulse_odd();
    test_valid_gaps();
    test_clear_mid_stream();
    test_back_to_back_random();
    test_rounding();
    test_saturation();
    test_wrap_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
